cic3_decim_capture: RTL
=======================

CIC3_DECIM_CAPTURE -- requirements
Module: cic3_decim_capture

Interface
REQ-001 The module SHALL have parameter DECIMATION_FACTOR, default 256, meaning the CIC decimation ratio; informational only, no RTL function depends on it.
REQ-002 The module SHALL have parameter CIC_WIDTH, default 25, meaning the width of the CIC output word.
REQ-003 The module SHALL have parameter OUT_WIDTH, default 16, meaning the width of a stored sample.
REQ-004 The module SHALL have parameter SETTLE_CYCLES, default 2, meaning the clk cycles waited after a divided_clk falling edge before sampling.
REQ-005 The module SHALL have parameter N_DISCARD, default 3, meaning the samples dropped after enable rises.
REQ-006 The module SHALL have parameter FIFO_DEPTH, default 8, meaning sample buffer entries (power of two).
REQ-007 The module SHALL have port clk, input, 1 bit: high-speed modulator clock, the only clock.
REQ-008 The module SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-009 The module SHALL have port enable, input, 1 bit: capture enable.
REQ-010 The module SHALL have port divided_clk, input, 1 bit: decimated clock, generated synchronously from clk.
REQ-011 The module SHALL have port cic_in, input, CIC_WIDTH bits: unsigned CIC filter output.
REQ-012 The module SHALL have port dout, output, OUT_WIDTH bits: FIFO head sample.
REQ-013 The module SHALL have port dout_valid, output, 1 bit: FIFO non-empty.
REQ-014 The module SHALL have port dout_ready, input, 1 bit: consumer accepts the head sample.
REQ-015 The module SHALL have port fill_level, output, $clog2(FIFO_DEPTH)+1 bits: number of stored samples.
REQ-016 The module SHALL have port overflow, output, 1 bit: sticky sample-dropped flag.
REQ-017 The module SHALL have port clear_ovf, input, 1 bit: clears overflow.

Function
REQ-018 The module SHALL register divided_clk each clk, and SHALL detect a falling edge in cycle k when the registered value is 1 and divided_clk is 0.
REQ-019 The module SHALL implement FSM states IDLE, WAIT_EDGE, SETTLE and CAPTURE.
REQ-020 The FSM SHALL make the following transitions:
- IDLE->WAIT_EDGE when enable=1;
- WAIT_EDGE->SETTLE on a falling edge;
- SETTLE->CAPTURE after exactly SETTLE_CYCLES cycles in SETTLE;
- CAPTURE->WAIT_EDGE after one cycle.
REQ-021 The FSM SHALL go to IDLE from any state in the cycle after enable=0; the FIFO contents SHALL be retained.
REQ-022 Falling edges occurring in SETTLE or CAPTURE SHALL be ignored.
REQ-023 In CAPTURE, the module SHALL sample cic_in; the sample is taken k+SETTLE_CYCLES+1 cycles after the edge cycle k.
REQ-024 Scaling SHALL be s = cic_in >> (CIC_WIDTH-OUT_WIDTH-1), saturated to 2^OUT_WIDTH-1.
- Default: 2^24 (full scale) -> 16'hFFFF.
- Default: 2^23 -> 16'h8000.
REQ-025 A discard counter SHALL be loaded with N_DISCARD on entry to WAIT_EDGE from IDLE; while it is nonzero, CAPTURE SHALL decrement it and SHALL NOT push.
REQ-026 When not discarding, CAPTURE SHALL push s into the FIFO; s SHALL appear at dout, with dout_valid=1, in the following cycle if the FIFO was empty (first-word-fall-through).
REQ-027 A pop SHALL occur when dout_valid=1 and dout_ready=1; dout_ready while empty SHALL have no effect.
REQ-028 A push with the FIFO full and no simultaneous pop SHALL drop the sample, leave the contents unchanged, and set overflow.
REQ-029 A simultaneous push and pop SHALL be honoured for any fill level, including full; fill_level SHALL be unchanged.
REQ-030 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-031 fill_level SHALL be registered and exact: 0..FIFO_DEPTH.
REQ-032 The overflow flag SHALL follow these rules:
- clear_ovf=1 SHALL clear overflow;
- a set and a clear in the same cycle SHALL resolve to set.

Reset
REQ-033 With reset=1 at a clk edge, the module SHALL enter state IDLE.
REQ-034 With reset=1 at a clk edge, the module SHALL clear the FIFO: pointers 0, fill_level=0, dout_valid=0.
REQ-035 With reset=1 at a clk edge, the module SHALL set dout=0, overflow=0, the registered divided_clk=0, and the settle and discard counters=0.
REQ-036 Reset SHALL take priority over all other inputs, including mid-SETTLE and mid-push.
REQ-037 After reset, the module SHALL NOT produce a spurious edge detection.

Verification
REQ-038 The bench SHALL cover basic capture. Stimulus: enable=1, divided_clk period 256, cic_in held at 25'h0800000. Required response: the first 3 samples are dropped, the 4th appears as dout=16'h8000 with dout_valid=1, SETTLE_CYCLES+2 cycles after its edge.
REQ-039 The bench SHALL cover saturation. Stimulus: cic_in=25'h1000000, then 25'h1FFFFFF. Required response: dout=16'hFFFF for both.
REQ-040 The bench SHALL cover overflow. Stimulus: dout_ready=0 for 9 post-discard samples. Required response: fill_level=8, overflow=1, the 9th sample is dropped, and dout equals the 1st sample. Then clear_ovf pulse -> overflow=0.
REQ-041 The bench SHALL cover the full-FIFO boundary. Stimulus: FIFO full, with a push cycle carrying dout_ready=1. Required response: fill_level stays 8, overflow stays 0, and order is preserved.
REQ-042 The bench SHALL cover reset mid-operation. Stimulus: reset=1 during SETTLE with fill_level=5. Required response: next cycle fill_level=0, dout_valid=0, state IDLE; after release with enable=1, N_DISCARD discards restart.
REQ-043 The bench SHALL cover an enable toggle. Stimulus: enable=0 for 1000 cycles with fill_level=3. Required response: no pushes and contents retained; on re-enable, 3 samples are discarded before the next push.

Source files
------------

// File: rtl/cic3_decim_capture.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cic3_decim_capture: samples a CIC3 output after each decimated-clock     |
// | falling edge, scales/saturates it and buffers it in an FWFT FIFO.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module cic3_decim_capture #(
  parameter int DECIMATION_FACTOR = 256,
  parameter int CIC_WIDTH         = 25,
  parameter int OUT_WIDTH         = 16,
  parameter int SETTLE_CYCLES     = 2,
  parameter int N_DISCARD         = 3,
  parameter int FIFO_DEPTH        = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          divided_clk,
  input  logic [CIC_WIDTH-1:0]          cic_in,
  output logic [OUT_WIDTH-1:0]          dout,
  output logic                          dout_valid,
  input  logic                          dout_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level,
  output logic                          overflow,
  input  logic                          clear_ovf
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int SHIFT = CIC_WIDTH - OUT_WIDTH - 1;
  localparam int SW    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int DW    = (N_DISCARD > 0) ? $clog2(N_DISCARD + 1) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [DW-1:0] DISC_LOAD   = DW'(N_DISCARD);
  localparam logic [AW:0]   FULL_LEVEL  = (AW + 1)'(FIFO_DEPTH);

  // The capture window (edge + settle + capture) must fit inside one decimated period.
  if (DECIMATION_FACTOR < SETTLE_CYCLES + 2) begin : g_chk_decim
    $error("DECIMATION_FACTOR too small for SETTLE_CYCLES");
  end

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_EDGE = 2'd1,
    S_SETTLE    = 2'd2,
    S_CAPTURE   = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_div_q;
  logic [SW-1:0]         r_settle;
  logic [DW-1:0]         r_disc;
  logic [OUT_WIDTH-1:0]  r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wptr;
  logic [AW-1:0]         r_rptr;
  logic [AW:0]           r_fill;
  logic                  r_ovf;

  logic                  w_fall;
  logic [CIC_WIDTH-1:0]  w_shifted;
  logic [OUT_WIDTH-1:0]  w_sample;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_wr;
  logic                  w_drop;

  assign w_fall    = r_div_q & ~divided_clk;
  assign w_shifted = cic_in >> SHIFT;
  assign w_sample  = (|w_shifted[CIC_WIDTH-1:OUT_WIDTH]) ? {OUT_WIDTH{1'b1}}
                                                         : w_shifted[OUT_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_div_q <= 1'b0;
    end else begin
      r_state <= w_next;
      r_div_q <= divided_clk;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (enable) w_next = S_WAIT_EDGE;
      S_WAIT_EDGE: if (w_fall) w_next = (SETTLE_CYCLES == 0) ? S_CAPTURE : S_SETTLE;
      S_SETTLE:    if (r_settle == SETTLE_LAST) w_next = S_CAPTURE;
      S_CAPTURE:   w_next = S_WAIT_EDGE;
      default:     w_next = S_IDLE;
    endcase
    if (!enable) w_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset || r_state != S_SETTLE) r_settle <= '0;
    else                              r_settle <= r_settle + 1'b1;
  end

  // Discard budget is re-armed only on leaving IDLE, so a disable/enable cycle restarts it.
  always_ff @(posedge clk) begin
    if (reset)                                     r_disc <= '0;
    else if (r_state == S_IDLE && enable)          r_disc <= DISC_LOAD;
    else if (r_state == S_CAPTURE && r_disc != '0) r_disc <= r_disc - 1'b1;
  end

  assign w_push = (r_state == S_CAPTURE) && (r_disc == '0);
  assign w_pop  = dout_valid & dout_ready;
  assign w_full = (r_fill == FULL_LEVEL);
  assign w_wr   = w_push & (~w_full | w_pop);
  assign w_drop = w_push & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (!reset && w_wr) r_mem[r_wptr] <= w_sample;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_fill <= '0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_fill <= r_fill + 1'b1;
        2'b01:   r_fill <= r_fill - 1'b1;
        default: r_fill <= r_fill;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset)          r_ovf <= 1'b0;
    else if (w_drop)    r_ovf <= 1'b1;
    else if (clear_ovf) r_ovf <= 1'b0;
  end

  assign dout_valid = (r_fill != '0);
  assign dout       = dout_valid ? r_mem[r_rptr] : '0;
  assign fill_level = r_fill;
  assign overflow   = r_ovf;

endmodule
`default_nettype wire
